sample_unpacker_expander: RTL and testbench
===========================================

Name: sample_unpacker_expander

Overview:
- TX-side counterpart of the RX 1-bit sign quantizer/packer.
- Accepts 16-bit packed words of 1-bit I/Q samples, e.g. from the DMA/host stream. Bit 0 is the oldest sample.
- Expands each bit to a full-scale signed 16-bit sample: bit 1 → +AMPLITUDE, bit 0 → −AMPLITUDE. One I/Q sample is emitted per accepted output cycle toward the DAC/interpolator chain.
- Two-word buffering so a continuous stream runs with no output bubbles.

Parameters:
AMPLITUDE, 16'sd8192, magnitude driven for a 1 bit; a 0 bit drives its two's-complement negation. Legal range 1..32767.

Ports:
aclk  in  1  clock, all logic rising-edge
aresetn  in  1  reset, asynchronous assert, active-low
s_tvalid  in  1  packed word valid
s_tready  out  1  block can take a packed word
packed_real  in  16  packed I bits, bit 0 first
packed_imag  in  16  packed Q bits, bit 0 first
m_tvalid  out  1  expanded sample valid
m_tready  in  1  downstream accepts sample
r  out  16  signed I sample
i  out  16  signed Q sample

Behaviour:
- Reset while aresetn low:
  - m_tvalid=0, r=0, i=0.
  - Both word slots empty; bit index=0.
  - s_tready forced 0; inputs ignored.
  - Reset mid-word discards all buffered bits.
- Storage:
  - nxt slot (one word) plus cur slot (one word) with a 4-bit index idx.
  - s_tready = aresetn & !nxt_valid, driven from registers only with no combinational path from s_tvalid or m_tready.
  - Input handshake (s_tvalid & s_tready) writes the word into nxt and sets nxt_valid.
- Output advance condition: adv = !m_tvalid | m_tready.
  - On adv with cur_valid: r ← packed_real bit idx expanded, i ← packed_imag bit idx expanded, m_tvalid←1, idx←idx+1 (mod 16).
  - On adv with cur empty: m_tvalid←0; r and i hold their last value.
  - While m_tvalid & !m_tready: m_tvalid, r and i are held stable.
- cur refill: when cur is empty, or on adv with idx==15, cur ← nxt, cur_valid ← nxt_valid, idx ← 0, nxt_valid ← 0. This happens in the same edge that consumes bit 15, so there is no bubble.
- Simultaneous events: a new accept and an nxt→cur transfer in the same edge cannot occur because s_tready=0 while nxt is full. nxt frees on the transfer edge and s_tready rises the next cycle.
- Latency:
  - Handshake at edge N puts the word in nxt.
  - Edge N+1 moves it to cur when cur is empty.
  - Edge N+2 gives m_tvalid=1 with bit 0.
- Throughput:
  - 1 sample/cycle sustained when m_tready=1.
  - 1 word per 16 cycles is sufficient and never bubbles once primed.
- Arithmetic: −AMPLITUDE is computed as a 16-bit two's complement constant at elaboration; there is no runtime arithmetic.
- Backpressure: the upstream word stays in nxt indefinitely; no sample is ever dropped or duplicated.

Optional Feature:
SAMPLE_UNPACKER_UNDERRUN_CNT_EN
- With the macro defined:
  - Adds output underrun_count [15:0], reset 0.
  - The counter increments on every adv cycle where cur is empty and no refill occurs, but only after the first word has ever been accepted.
  - The counter saturates at 16'hFFFF.
  - It is cleared only by reset.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single-word test:
  - Stimulus: reset, then one word packed_real=16'hA5A5, packed_imag=16'h0001, m_tready=1.
  - Required: m_tvalid high for exactly 16 cycles, starting 2 cycles after the handshake.
  - r sequence: +8192, −8192, +8192, −8192, −8192, +8192, −8192, +8192, then the same 8 values again.
  - i: +8192 on the first sample, −8192 on the next 15.
  - Then m_tvalid=0.
- Back-to-back words:
  - Stimulus: words 16'hFFFF and 16'h0000 offered continuously on both lanes.
  - Required: 16 samples of +8192 followed immediately by 16 of −8192, with no m_tvalid gap at the boundary.
  - s_tready deasserts while nxt is full.
- Backpressure:
  - Stimulus: m_tready low for 5 cycles at sample 7 of word 16'h00F0.
  - Required: r held at the bit-7 value (+8192) with m_tvalid=1 throughout the stall; sample order resumes intact; 16 samples total.
- Mid-word reset:
  - Stimulus: assert aresetn=0 after 4 samples of a word, with a second word buffered.
  - Required: m_tvalid=0 and r=i=0 immediately (asynchronous); s_tready=0 during reset, 1 one cycle after release; no residual samples emitted.
- Parameter and underrun check:
  - Stimulus: AMPLITUDE=32767 with word 16'h0001; with the macro defined, idle 10 cycles after that word drains.
  - Required: samples 16'h7FFF then 15× 16'h8001; underrun_count=10.

Source files
------------

// File: rtl/sample_unpacker_expander_if.sv
// Purpose     : bundles the packed-word input stream and the expanded I/Q sample stream.
// Latency     : n/a (signal bundle only).
// Backpressure: s_tready/m_tready valid-ready pairs; the block side is the 'slave' modport.
//
// Signals:
//   s_tvalid/s_tready          packed word handshake
//   packed_real/packed_imag    16 packed I/Q sign bits, bit 0 is the oldest sample
//   m_tvalid/m_tready          expanded sample handshake
//   r/i                        signed 16-bit I/Q sample
interface sample_unpacker_expander_if;
    logic               s_tvalid;
    logic               s_tready;
    logic        [15:0] packed_real;
    logic        [15:0] packed_imag;
    logic               m_tvalid;
    logic               m_tready;
    logic signed [15:0] r;
    logic signed [15:0] i;

    // Environment side: produces packed words, consumes samples.
    modport master (
        output s_tvalid, packed_real, packed_imag, m_tready,
        input  s_tready, m_tvalid, r, i
    );

    // Unpacker side: consumes packed words, produces samples.
    modport slave (
        input  s_tvalid, packed_real, packed_imag, m_tready,
        output s_tready, m_tvalid, r, i
    );
endinterface

// File: rtl/sample_unpacker_expander.sv
// Purpose     : expands 16-bit packed 1-bit I/Q words into full-scale signed 16-bit samples.
// Latency     : word accepted at edge N, bit 0 presented after edge N+2; then 1 sample/cycle.
// Backpressure: m_tready low holds the sample; the word in the nxt slot holds s_tready low.
//
// Ports:
//   aclk            rising-edge clock
//   aresetn         asynchronous active-low reset
//   bus (slave)     s_tvalid/s_tready/packed_real/packed_imag in, m_tvalid/m_tready/r/i out
//   underrun_count  saturating count of starved output cycles (only with
//                   SAMPLE_UNPACKER_UNDERRUN_CNT_EN defined)
//
// Two word slots: 'nxt' catches the upstream word, 'cur' is being serialised
// bit by bit. cur reloads from nxt in the same edge that emits bit 15, so a
// stream that keeps nxt filled never shows an output bubble.
module sample_unpacker_expander #(
    parameter logic signed [15:0] AMPLITUDE = 16'sd8192
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    sample_unpacker_expander_if.slave     bus
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_count
`endif
);

    // Both output levels are elaboration-time constants.
    localparam logic signed [15:0] POS_AMP = AMPLITUDE;
    localparam logic signed [15:0] NEG_AMP = -AMPLITUDE;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic        [15:0] nxt_real_q, nxt_real_d;
    logic        [15:0] nxt_imag_q, nxt_imag_d;
    logic               nxt_vld_q,  nxt_vld_d;
    logic        [15:0] cur_real_q, cur_real_d;
    logic        [15:0] cur_imag_q, cur_imag_d;
    logic               cur_vld_q,  cur_vld_d;
    logic        [3:0]  idx_q,      idx_d;
    logic               m_vld_q,    m_vld_d;
    logic signed [15:0] r_q,        r_d;
    logic signed [15:0] i_q,        i_d;
    logic               s_rdy_q,    s_rdy_d;

    logic adv;
    logic accept;
    logic last_bit;
    logic refill;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        nxt_real_d = nxt_real_q;
        nxt_imag_d = nxt_imag_q;
        nxt_vld_d  = nxt_vld_q;
        cur_real_d = cur_real_q;
        cur_imag_d = cur_imag_q;
        cur_vld_d  = cur_vld_q;
        idx_d      = idx_q;
        m_vld_d    = m_vld_q;
        r_d        = r_q;
        i_d        = i_q;

        // Output register may load whenever it is empty or being drained.
        adv      = !m_vld_q | bus.m_tready;
        // s_rdy_q mirrors !nxt_vld_q, so an accept only ever lands in an empty nxt.
        accept   = bus.s_tvalid & s_rdy_q;
        last_bit = adv & cur_vld_q & (idx_q == 4'd15);
        // An empty cur reloads every edge; if nxt is also empty it simply stays empty.
        refill   = !cur_vld_q | last_bit;

        if (adv) begin
            if (cur_vld_q) begin
                r_d     = cur_real_q[idx_q] ? POS_AMP : NEG_AMP;
                i_d     = cur_imag_q[idx_q] ? POS_AMP : NEG_AMP;
                m_vld_d = 1'b1;
                idx_d   = idx_q + 4'd1;
            end else begin
                // Starved: drop valid, leave r/i at their last value.
                m_vld_d = 1'b0;
            end
        end

        if (refill) begin
            cur_real_d = nxt_real_q;
            cur_imag_d = nxt_imag_q;
            cur_vld_d  = nxt_vld_q;
            idx_d      = 4'd0;
            nxt_vld_d  = 1'b0;
        end

        // Applied after refill: when both happen, nxt was empty before the
        // edge, so the transfer moved nothing and the new word stays in nxt.
        if (accept) begin
            nxt_real_d = bus.packed_real;
            nxt_imag_d = bus.packed_imag;
            nxt_vld_d  = 1'b1;
        end

        // Registered ready: no combinational path from s_tvalid or m_tready.
        s_rdy_d = !nxt_vld_d;
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            nxt_real_q <= 16'd0;
            nxt_imag_q <= 16'd0;
            nxt_vld_q  <= 1'b0;
            cur_real_q <= 16'd0;
            cur_imag_q <= 16'd0;
            cur_vld_q  <= 1'b0;
            idx_q      <= 4'd0;
            m_vld_q    <= 1'b0;
            r_q        <= 16'sd0;
            i_q        <= 16'sd0;
            s_rdy_q    <= 1'b0;
        end else begin
            nxt_real_q <= nxt_real_d;
            nxt_imag_q <= nxt_imag_d;
            nxt_vld_q  <= nxt_vld_d;
            cur_real_q <= cur_real_d;
            cur_imag_q <= cur_imag_d;
            cur_vld_q  <= cur_vld_d;
            idx_q      <= idx_d;
            m_vld_q    <= m_vld_d;
            r_q        <= r_d;
            i_q        <= i_d;
            s_rdy_q    <= s_rdy_d;
        end
    end

    assign bus.s_tready = s_rdy_q;
    assign bus.m_tvalid = m_vld_q;
    assign bus.r        = r_q;
    assign bus.i        = i_q;

`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
    // ---------------------------------------------------------------
    // Underrun counter: starved output cycles once traffic has started.
    // Idle time before the very first word is not an underrun.
    // ---------------------------------------------------------------
    logic        seen_q, seen_d;
    logic [15:0] urun_q, urun_d;
    logic        urun_inc;

    always_comb begin
        seen_d   = seen_q | accept;
        // cur empty with nothing in nxt: the refill this edge brings no data.
        urun_inc = seen_q & adv & !cur_vld_q & !nxt_vld_q;
        urun_d   = urun_q;
        if (urun_inc && (urun_q != 16'hFFFF)) begin
            urun_d = urun_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seen_q <= 1'b0;
            urun_q <= 16'd0;
        end else begin
            seen_q <= seen_d;
            urun_q <= urun_d;
        end
    end

    assign underrun_count = urun_q;
`endif

endmodule

// File: tb/tb_sample_unpacker_expander.sv
// Purpose     : self-checking bench for sample_unpacker_expander (two instances, two amplitudes).
// Latency     : n/a.
// Backpressure: drives random and directed m_tready stalls; stalled samples must hold.
module tb_sample_unpacker_expander;

    localparam logic signed [15:0] AMP_A = 16'sd8192;
    localparam logic signed [15:0] AMP_M = 16'sd32767;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    sample_unpacker_expander_if ba();
    sample_unpacker_expander_if bm();

    logic rand_rdy = 1'b0;
    logic rdy_rnd  = 1'b1;
    logic rdy_man  = 1'b1;
    assign ba.m_tready = rand_rdy ? rdy_rnd : rdy_man;
    assign bm.m_tready = 1'b1;

`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
    logic [15:0] urun_a;
    logic [15:0] urun_m;
`endif

    sample_unpacker_expander #(.AMPLITUDE(AMP_A)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .bus            (ba)
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        ,
        .underrun_count (urun_a)
`endif
    );

    sample_unpacker_expander #(.AMPLITUDE(AMP_M)) dut_max (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .bus            (bm)
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        ,
        .underrun_count (urun_m)
`endif
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int popped   = 0;

    // Expected sample streams for instance 'dut', oldest first.
    logic [15:0] exp_r_q[$];
    logic [15:0] exp_i_q[$];

    function automatic logic [15:0] expand(input logic b, input logic [15:0] amp);
        return b ? amp : (~amp + 16'd1);
    endfunction

    function automatic logic [15:0] b16(input logic b);
        return {15'd0, b};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge aclk) begin
        #1;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every accepted word appends 16 expected samples; every
    // output handshake pops one; a stalled sample must not change.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_r, prev_i, er, ei;
        prev_stall = 1'b0;
        prev_r     = 16'd0;
        prev_i     = 16'd0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                exp_r_q.delete();
                exp_i_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_vld", b16(ba.m_tvalid), 16'd1);
                    chk("stall_r", ba.r, prev_r);
                    chk("stall_i", ba.i, prev_i);
                end
                if (ba.m_tvalid && ba.m_tready) begin
                    chk_cnt++;
                    if (exp_r_q.size() == 0) begin
                        $display("FAIL extra_sample: got r=%h i=%h expected no sample at %0t",
                                 ba.r, ba.i, $time);
                    end else begin
                        pass_cnt++;
                        er = exp_r_q.pop_front();
                        ei = exp_i_q.pop_front();
                        chk("sample_r", ba.r, er);
                        chk("sample_i", ba.i, ei);
                        popped++;
                    end
                end
                if (ba.s_tvalid && ba.s_tready) begin
                    for (int k = 0; k < 16; k++) begin
                        exp_r_q.push_back(expand(ba.packed_real[k], AMP_A));
                        exp_i_q.push_back(expand(ba.packed_imag[k], AMP_A));
                    end
                end
                prev_stall = ba.m_tvalid && !ba.m_tready;
                prev_r     = ba.r;
                prev_i     = ba.i;
            end
        end
    end

    // Offer one word to 'dut'; returns 1 ns after the accepting edge.
    task automatic send_a(input logic [15:0] wr, input logic [15:0] wi);
        int t;
        t = 0;
        @(posedge aclk);
        #1;
        ba.s_tvalid    = 1'b1;
        ba.packed_real = wr;
        ba.packed_imag = wi;
        @(negedge aclk);
        while (!ba.s_tready && t < 300) begin
            @(negedge aclk);
            t++;
        end
        chk("send_ready", b16(ba.s_tready), 16'd1);
        @(posedge aclk);
        #1;
        ba.s_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while ((exp_r_q.size() != 0 || ba.m_tvalid) && t < 3000);
        chk("drain", 16'(exp_r_q.size()), 16'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] rs [64];
        logic [15:0] is [64];
        logic [15:0] pat [8];
        int n, t, cnt, base;

        pat = '{16'h2000, 16'hE000, 16'h2000, 16'hE000,
                16'hE000, 16'h2000, 16'hE000, 16'h2000};
        ba.s_tvalid = 1'b0; ba.packed_real = 16'd0; ba.packed_imag = 16'd0;
        bm.s_tvalid = 1'b0; bm.packed_real = 16'd0; bm.packed_imag = 16'd0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge aclk);
        chk("rst_vld", b16(ba.m_tvalid), 16'd0);
        chk("rst_r", ba.r, 16'd0);
        chk("rst_i", ba.i, 16'd0);
        chk("rst_rdy", b16(ba.s_tready), 16'd0);
        chk("rst_vld_max", b16(bm.m_tvalid), 16'd0);
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        chk("rst_urun", urun_a, 16'd0);
`endif
        @(posedge aclk); #1; aresetn = 1'b1;

        // ---------------- single word ----------------
        rdy_man = 1'b1;
        send_a(16'hA5A5, 16'h0001);
        @(negedge aclk); chk("lat_edge_n", b16(ba.m_tvalid), 16'd0);
        @(negedge aclk); chk("lat_edge_n1", b16(ba.m_tvalid), 16'd0);
        @(negedge aclk); chk("lat_edge_n2", b16(ba.m_tvalid), 16'd1);
        cnt = 0;
        while (ba.m_tvalid && cnt < 40) begin
            rs[cnt] = ba.r;
            is[cnt] = ba.i;
            cnt++;
            @(negedge aclk);
        end
        chk("single_count", 16'(cnt), 16'd16);
        chk("single_end", b16(ba.m_tvalid), 16'd0);
        for (int k = 0; k < 16; k++) begin
            chk("single_r", rs[k], pat[k % 8]);
            chk("single_i", is[k], (k == 0) ? 16'h2000 : 16'hE000);
        end
        wait_idle();

        // ---------------- back-to-back ----------------
        fork
            begin
                send_a(16'hFFFF, 16'hFFFF);
                @(negedge aclk); chk("rdy_nxt_full1", b16(ba.s_tready), 16'd0);
                send_a(16'h0000, 16'h0000);
                @(negedge aclk); chk("rdy_nxt_full2", b16(ba.s_tready), 16'd0);
            end
            begin
                int tb, run;
                tb = 0; run = 0;
                while (!ba.m_tvalid && tb < 100) begin
                    @(negedge aclk);
                    tb++;
                end
                while (ba.m_tvalid && run < 64) begin
                    rs[run] = ba.r;
                    run++;
                    @(negedge aclk);
                end
                chk("b2b_run", 16'(run), 16'd32);
                for (int k = 0; k < 32; k++)
                    chk("b2b_r", rs[k], (k < 16) ? 16'h2000 : 16'hE000);
            end
        join
        wait_idle();

        // ---------------- backpressure ----------------
        base = popped;
        fork
            send_a(16'h00F0, 16'h0F0F);
            begin
                n = 0; t = 0;
                while (n < 7 && t < 200) begin
                    @(negedge aclk);
                    t++;
                    if (ba.m_tvalid && ba.m_tready) n++;
                end
            end
        join
        @(posedge aclk); #1; rdy_man = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            chk("bp_hold_vld", b16(ba.m_tvalid), 16'd1);
            chk("bp_hold_r", ba.r, 16'h2000);
        end
        @(posedge aclk); #1; rdy_man = 1'b1;
        wait_idle();
        chk("bp_total", 16'(popped - base), 16'd16);

        // ---------------- random traffic ----------------
        rand_rdy = 1'b1;
        for (int w = 0; w < 40; w++) begin
            repeat ($urandom_range(0, 24)) @(posedge aclk);
            send_a(16'($urandom), 16'($urandom));
        end
        wait_idle();
        rand_rdy = 1'b0;

        // ---------------- mid-word reset ----------------
        rdy_man = 1'b1;
        send_a(16'h1234, 16'h5678);
        send_a(16'h9ABC, 16'hDEF0);
        n = 0; t = 0;
        while (n < 4 && t < 100) begin
            @(negedge aclk);
            t++;
            if (ba.m_tvalid && ba.m_tready) n++;
        end
        chk("mid_samples", 16'(n), 16'd4);
        @(posedge aclk); #1; aresetn = 1'b0;
        #1;
        chk("mid_rst_vld", b16(ba.m_tvalid), 16'd0);
        chk("mid_rst_r", ba.r, 16'd0);
        chk("mid_rst_i", ba.i, 16'd0);
        chk("mid_rst_rdy", b16(ba.s_tready), 16'd0);
        repeat (3) @(negedge aclk);
        chk("mid_rst_rdy_hold", b16(ba.s_tready), 16'd0);
        @(posedge aclk); #1; aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rdy_after_release", b16(ba.s_tready), 16'd1);
        n = 0;
        repeat (30) begin
            @(negedge aclk);
            if (ba.m_tvalid) n++;
        end
        chk("no_residual", 16'(n), 16'd0);

        // ---------------- full-scale amplitude + underrun ----------------
        @(posedge aclk); #1;
        bm.s_tvalid = 1'b1; bm.packed_real = 16'h0001; bm.packed_imag = 16'h0001;
        t = 0;
        @(negedge aclk);
        while (!bm.s_tready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("max_send_ready", b16(bm.s_tready), 16'd1);
        @(posedge aclk); #1; bm.s_tvalid = 1'b0;
        cnt = 0; t = 0;
        while (cnt < 16 && t < 100) begin
            @(negedge aclk);
            t++;
            if (bm.m_tvalid) begin
                chk("max_r", bm.r, (cnt == 0) ? 16'h7FFF : 16'h8001);
                chk("max_i", bm.i, (cnt == 0) ? 16'h7FFF : 16'h8001);
                cnt++;
            end
        end
        chk("max_count", 16'(cnt), 16'd16);
        n = 0; base = 0; t = 0;
        while (n < 10 && t < 100) begin
            @(negedge aclk);
            t++;
            if (bm.m_tvalid) base++;
            else n++;
        end
        chk("max_idle_cycles", 16'(n), 16'd10);
        chk("max_no_extra", 16'(base), 16'd0);
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        chk("underrun_count", urun_m, 16'd10);
`endif

        chk("sb_empty", 16'(exp_r_q.size()), 16'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
